calculate_cycles: RTL

Converts a signed fixed-point time interval `dt` into an integer clock-cycle count: `cycles = floor(dt / SEC_PER_CYCLE)`. It uses a sequential restoring divider that produces one quotient bit per clock. It is the inverse of the Δt calculation in the control loop, and turns requested delays and periods from the host-side time format back into counts for the loop timers. The output is saturated so that it is always a non-negative value that can be fed back into the Δt multiplier (leading zero guaranteed).

---
 rtl/calculate_cycles_if.sv | 14 +
 rtl/calculate_cycles.sv | 121 ++++++++++++
 2 files changed

// File: rtl/calculate_cycles_if.sv
// rtl/calculate_cycles_if.sv - request/result bundle for the dt-to-cycles divider
interface calculate_cycles_if #(
  parameter int DT_WID          = 33,
  parameter int CYCLE_COUNT_WID = 18
);
  logic                       arm;
  logic [DT_WID-1:0]          dt;
  logic                       finished;
  logic [CYCLE_COUNT_WID-1:0] cycles;
  logic                       saturated;

  modport master (output arm, dt, input finished, cycles, saturated);
  modport slave  (input arm, dt, output finished, cycles, saturated);
endinterface

// File: rtl/calculate_cycles.sv
// rtl/calculate_cycles.sv - floor(dt / SEC_PER_CYCLE) via restoring division, one quotient bit per clock
module calculate_cycles #(
  parameter int                           SEC_PER_CYCLE_WID = 15,
  parameter logic [SEC_PER_CYCLE_WID-1:0] SEC_PER_CYCLE     = 15'b010101011110011,
  parameter int                           CYCLE_COUNT_WID   = 18,
  parameter int                           DT_WID            = 33
) (
  input  logic              clk,
  input  logic              rst,
  calculate_cycles_if.slave bus
);

  localparam int SPW     = SEC_PER_CYCLE_WID;
  localparam int CW      = CYCLE_COUNT_WID;
  localparam int CNT_WID = $clog2(DT_WID + 1);
  localparam logic [CW-1:0]  MAX_CYCLES = {1'b0, {(CW-1){1'b1}}};
  localparam logic [SPW+1:0] SPC_W      = {2'b00, SEC_PER_CYCLE};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DT_WID-1:0]  div_q, div_d;
  logic [DT_WID-1:0]  quo_q, quo_d;
  logic [SPW:0]       rem_q, rem_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic [CW-1:0]      cycles_q, cycles_d;
  logic               sat_q, sat_d;

  logic [SPW+1:0]     rem_wide;
  logic               rem_ge;
  logic               quo_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.arm) state_d = bus.dt[DT_WID-1] ? S_DONE : S_RUN;
      S_RUN: begin
        if (!bus.arm)        state_d = S_IDLE;
        else if (cnt_q == 0) state_d = S_DONE;
      end
      S_DONE: if (!bus.arm) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.finished  = (state_q == S_DONE);
    bus.cycles    = cycles_q;
    bus.saturated = sat_q;
  end

  // Remainder never exceeds SEC_PER_CYCLE, so one extra bit holds the shifted value.
  assign rem_wide = {rem_q, div_q[DT_WID-1]};
  assign rem_ge   = (rem_wide >= SPC_W);
  assign quo_ovf  = (quo_q > DT_WID'(MAX_CYCLES));

  always_comb begin
    div_d    = div_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    sat_d    = sat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          if (bus.dt[DT_WID-1]) begin
            cycles_d = '0;
            sat_d    = 1'b1;
          end else begin
            div_d = bus.dt;
            quo_d = '0;
            rem_d = '0;
            cnt_d = CNT_WID'(DT_WID);
          end
        end
      end
      S_RUN: begin
        if (bus.arm) begin
          if (cnt_q != 0) begin
            div_d = {div_q[DT_WID-2:0], 1'b0};
            quo_d = {quo_q[DT_WID-2:0], rem_ge};
            rem_d = (SPW+1)'(rem_ge ? rem_wide - SPC_W : rem_wide);
            cnt_d = cnt_q - CNT_WID'(1);
          end else begin
            cycles_d = quo_ovf ? MAX_CYCLES : quo_q[CW-1:0];
            sat_d    = quo_ovf;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      sat_q    <= sat_d;
    end
  end

endmodule
